// File: rtl/npu_inference_capture_ctrl.sv
// Capture sequencer for NPU inference results into port A of the result memory.
// Handles single-shot/continuous capture, a zero-fill clear sweep and dropped-result counting.
module npu_inference_capture_ctrl #(
  parameter int RES_WIDTH  = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  infer_valid,
  input  logic [RES_WIDTH-1:0]  infer_data,
  input  logic [31:0]           sw_ctrl,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [RES_WIDTH-1:0]  mem_din,
  output logic                  mem_we,
  output logic                  capture_done,
  output logic [31:0]           status
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ZERO_PTR  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH:0]   ZERO_CNT  = {(ADDR_WIDTH + 1){1'b0}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2,
    CLEAR   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           sw_ctrl_q, sw_ctrl_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [RES_WIDTH-1:0]  mem_din_q, mem_din_d;
  logic                  capture_done_q, capture_done_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic                  done_q, done_d;
  logic [RES_WIDTH-1:0]  last_q, last_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic [31:0]           status_q, status_d;

  logic [31:0]           cmd;
  logic                  cmd_arm, cmd_clear, cmd_stop, cont_mode;
  logic                  drop_inc;
  logic [ADDR_WIDTH-1:0] base_ptr;
  logic [ADDR_WIDTH:0]   base_cnt;
  logic                  base_wrap;
  logic [3:0]            last_nib;
  logic [7:0]            count_byte;
  logic                  unused_sw;

  assign cmd       = sw_ctrl & ~sw_ctrl_q;
  assign cmd_arm   = cmd[0];
  assign cmd_clear = cmd[1];
  assign cmd_stop  = cmd[3];
  assign cont_mode = sw_ctrl[2];
  assign unused_sw = ^{cmd[31:4], cmd[2]};

  assign last_nib   = 4'(last_q);
  assign count_byte = 8'(count_q);

  // Next-state, memory-port and bookkeeping decode.
  always_comb begin
    state_d        = state_q;
    sw_ctrl_d      = sw_ctrl;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_din_d      = mem_din_q;
    capture_done_d = 1'b0;
    wr_ptr_d       = wr_ptr_q;
    clr_ptr_d      = clr_ptr_q;
    count_d        = count_q;
    wrap_d         = wrap_q;
    done_d         = done_q;
    last_d         = last_q;
    drop_cnt_d     = drop_cnt_q;
    drop_inc       = 1'b0;
    base_ptr       = wr_ptr_q;
    base_cnt       = count_q;
    base_wrap      = wrap_q;

    if (cmd_clear) begin
      // Clear outranks every other command in every state and restarts any sweep.
      state_d    = CLEAR;
      clr_ptr_d  = ZERO_PTR;
      count_d    = ZERO_CNT;
      wrap_d     = 1'b0;
      done_d     = 1'b0;
      drop_cnt_d = 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_arm) begin
            state_d  = CAPTURE;
            wr_ptr_d = ZERO_PTR;
            count_d  = ZERO_CNT;
            wrap_d   = 1'b0;
            done_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        CAPTURE: begin
          if (cmd_arm) begin
            base_ptr  = ZERO_PTR;
            base_cnt  = ZERO_CNT;
            base_wrap = 1'b0;
          end else begin
            base_ptr  = wr_ptr_q;
            base_cnt  = count_q;
            base_wrap = wrap_q;
          end
          if (cmd_stop && !cmd_arm) begin
            state_d        = DONE;
            done_d         = 1'b1;
            capture_done_d = 1'b1;
            drop_inc       = infer_valid;
          end else begin
            wr_ptr_d = base_ptr;
            count_d  = base_cnt;
            wrap_d   = base_wrap;
            done_d   = 1'b0;
            if (infer_valid) begin
              mem_we_d   = 1'b1;
              mem_addr_d = base_ptr;
              mem_din_d  = infer_data;
              last_d     = infer_data;
              wr_ptr_d   = base_ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
              count_d    = (base_cnt == DEPTH_CNT) ? DEPTH_CNT
                                                   : base_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
              if (cont_mode) begin
                // Wrap marks the first overwrite of a fully captured buffer.
                if ((base_ptr == ZERO_PTR) && (base_cnt == DEPTH_CNT)) begin
                  wrap_d = 1'b1;
                end else begin
                  wrap_d = base_wrap;
                end
              end else if (count_d == DEPTH_CNT) begin
                state_d        = DONE;
                done_d         = 1'b1;
                capture_done_d = 1'b1;
              end else begin
                state_d = CAPTURE;
              end
            end else begin
              state_d = CAPTURE;
            end
          end
        end
        DONE: begin
          drop_inc = infer_valid;
          if (cmd_arm) begin
            state_d  = CAPTURE;
            wr_ptr_d = ZERO_PTR;
            count_d  = ZERO_CNT;
            wrap_d   = 1'b0;
            done_d   = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
        CLEAR: begin
          drop_inc   = infer_valid;
          mem_we_d   = 1'b1;
          mem_addr_d = clr_ptr_q;
          mem_din_d  = {RES_WIDTH{1'b0}};
          clr_ptr_d  = clr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          if (clr_ptr_q == LAST_PTR) begin
            state_d  = IDLE;
            wr_ptr_d = ZERO_PTR;
          end else begin
            state_d = CLEAR;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'h0001;
    end else begin
      drop_cnt_d = drop_cnt_d;
    end

    status_d = {state_q, wrap_q, done_q, last_nib, count_byte, drop_cnt_q};
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      sw_ctrl_q      <= 32'h0000_0000;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= ZERO_PTR;
      mem_din_q      <= {RES_WIDTH{1'b0}};
      capture_done_q <= 1'b0;
      wr_ptr_q       <= ZERO_PTR;
      clr_ptr_q      <= ZERO_PTR;
      count_q        <= ZERO_CNT;
      wrap_q         <= 1'b0;
      done_q         <= 1'b0;
      last_q         <= {RES_WIDTH{1'b0}};
      drop_cnt_q     <= 16'h0000;
      status_q       <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      sw_ctrl_q      <= sw_ctrl_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_din_q      <= mem_din_d;
      capture_done_q <= capture_done_d;
      wr_ptr_q       <= wr_ptr_d;
      clr_ptr_q      <= clr_ptr_d;
      count_q        <= count_d;
      wrap_q         <= wrap_d;
      done_q         <= done_d;
      last_q         <= last_d;
      drop_cnt_q     <= drop_cnt_d;
      status_q       <= status_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_din      = mem_din_q;
  assign capture_done = capture_done_q;
  assign status       = status_q;

endmodule

// File: tb/tb_npu_inference_capture_ctrl.sv
// Table-driven bench for npu_inference_capture_ctrl: per-cycle vectors flow through a
// scoreboard queue and are compared one edge after they are driven.
module tb_npu_inference_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        infer_valid;
  logic [3:0]  infer_data;
  logic [31:0] sw_ctrl;
  logic [1:0]  mem_addr;
  logic [3:0]  mem_din;
  logic        mem_we;
  logic        capture_done;
  logic [31:0] status;

  npu_inference_capture_ctrl #(.RES_WIDTH(4), .ADDR_WIDTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .infer_valid  (infer_valid),
    .infer_data   (infer_data),
    .sw_ctrl      (sw_ctrl),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_we       (mem_we),
    .capture_done (capture_done),
    .status       (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] sw;
    logic        vld;
    logic [3:0]  din;
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  wd;
    logic        cd;
    logic        chk_st;
    logic [31:0] st;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   total  = 0;
  int   passed = 0;

  task automatic add(input logic rst, input logic [31:0] sw, input logic vld, input logic [3:0] din,
                     input logic we, input logic [1:0] addr, input logic [3:0] wd, input logic cd,
                     input logic chk_st, input logic [31:0] st);
    vec_t v;
    v.rst = rst; v.sw = sw; v.vld = vld; v.din = din; v.we = we;
    v.addr = addr; v.wd = wd; v.cd = cd; v.chk_st = chk_st; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
  endtask

  initial begin
    vec_t e;
    reset = 1'b1; infer_valid = 1'b0; infer_data = 4'h0; sw_ctrl = 32'h0;

    // T1 single-shot capture of four results
    add(1'b0, 32'h1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h1, 1'b1, 4'h3, 1'b1, 2'd0, 4'h3, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h1, 1'b1, 4'h7, 1'b1, 2'd1, 4'h7, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h1, 1'b1, 4'h1, 1'b1, 2'd2, 4'h1, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h1, 1'b1, 4'h9, 1'b1, 2'd3, 4'h9, 1'b1, 1'b0, 32'h0);
    add(1'b0, 32'h1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 32'h9904_0000);
    // T2 drops in DONE, then clear sweep
    for (int i = 0; i < 3; i++) add(1'b0, 32'h1, 1'b1, 4'h5, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 32'h9904_0003);
    add(1'b0, 32'h3, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h3, 1'b0, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 1'b1, 32'hC900_0000);
    for (int i = 1; i < 4; i++) add(1'b0, 32'h3, 1'b0, 4'h0, 1'b1, 2'(i), 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h3, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 32'h0900_0000);
    // T3 continuous capture wraps the buffer
    add(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h5, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 6; i++) add(1'b0, 32'h5, 1'b1, 4'(i), 1'b1, 2'((i - 1) % 4), 4'(i), 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h5, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 32'h6604_0000);
    // T4 clear beats arm; arm with same-cycle valid restarts at address 0
    add(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h3, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h3, 1'b0, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 1'b1, 32'hC600_0000);
    for (int i = 1; i < 4; i++) add(1'b0, 32'h3, 1'b0, 4'h0, 1'b1, 2'(i), 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 32'h0600_0000);
    add(1'b0, 32'h1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h1, 1'b1, 4'h5, 1'b1, 2'd0, 4'h5, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h1, 1'b1, 4'hA, 1'b1, 2'd0, 4'hA, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 32'h4A01_0000);
    // T5 held arm is one command; stop with same-cycle valid drops it
    add(1'b0, 32'h2, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h2, 1'b0, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 1'b1, 32'hCA00_0000);
    for (int i = 1; i < 4; i++) add(1'b0, 32'h2, 1'b0, 4'h0, 1'b1, 2'(i), 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b1, 4'hF, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 32'h0A00_0000);
    add(1'b0, 32'h1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h1, 1'b1, 4'h1, 1'b1, 2'd0, 4'h1, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h1, 1'b1, 4'h2, 1'b1, 2'd1, 4'h2, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 7; i++) add(1'b0, 32'h1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h1, 1'b1, 4'h3, 1'b1, 2'd2, 4'h3, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h9, 1'b1, 4'h4, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 32'h0);
    add(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 32'h9303_0001);
    // T6 reset in the middle of a clear sweep
    add(1'b0, 32'h2, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h2, 1'b0, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 32'h2, 1'b0, 4'h0, 1'b1, 2'd1, 4'h0, 1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h2, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 32'h0);
    add(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_we", -1, 32'(mem_we), 32'h0);
    chk("reset_addr", -1, 32'(mem_addr), 32'h0);
    chk("reset_din", -1, 32'(mem_din), 32'h0);
    chk("reset_done", -1, 32'(capture_done), 32'h0);
    chk("reset_status", -1, status, 32'h0);

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      reset       = vecs[r].rst;
      sw_ctrl     = vecs[r].sw;
      infer_valid = vecs[r].vld;
      infer_data  = vecs[r].din;
      sb.push_back(vecs[r]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("mem_we", r, 32'(mem_we), 32'(e.we));
      if (e.we) begin
        chk("mem_addr", r, 32'(mem_addr), 32'(e.addr));
        chk("mem_din", r, 32'(mem_din), 32'(e.wd));
      end
      chk("capture_done", r, 32'(capture_done), 32'(e.cd));
      if (e.chk_st) chk("status", r, status, e.st);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
